fetch_sequencer: RTL and testbench

//  Owns the architectural PC and sequences instruction fetch for the 16-bit pipeline.

---
 rtl/fetch_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the architectural PC and sequences instruction fetch
// for the 16-bit pipeline. Talks to a variable-latency instruction memory,
// delivers instructions to IF/ID, absorbs one stalled response in a skid
// register, applies taken-branch redirects from ID and stops fetch on HLT.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        hlt_dec,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_vld,
    input  logic [15:0] imem_data,
    output logic        if_vld,
    output logic [15:0] if_inst,
    output logic [15:0] if_pc_plus2,
    output logic        flush,
    output logic        halted,
    output logic [15:0] pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_SKID  = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic        req_q;
    logic [15:0] req_addr_q;
    logic [15:0] skid_q;
    logic [15:0] skid_pc2_q;
    logic        halt_pend_q;
    logic        if_vld_q;
    logic [15:0] if_inst_q;
    logic [15:0] if_pc2_q;
    logic        flush_q;
    logic        halted_q;

    logic [15:0] pc_plus2_d;
    logic        rsp_d;
    logic        br_d;
    logic        hlt_d;

    // Qualified events: a response only counts while a request is out, and
    // ID events are ignored while the hazard unit holds the pipeline.
    always_comb begin
        pc_plus2_d = pc_q + 16'd2;
        rsp_d      = imem_vld & req_q;
        br_d       = branch_taken & ~stall;
        hlt_d      = hlt_dec & ~stall;
    end

    // Fetch FSM with all outputs registered; req_q tracks the next state so
    // the request drops the same edge the FSM leaves FETCH/DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            if_vld_q    <= 1'b0;
            if_inst_q   <= NOP_INST;
            if_pc2_q    <= 16'h0000;
            flush_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    req_q <= 1'b1;
                    if (stall) begin
                        // Response during a stall parks in the skid register.
                        if (rsp_d) begin
                            skid_q     <= imem_data;
                            skid_pc2_q <= pc_plus2_d;
                            pc_q       <= pc_plus2_d;
                            state_q    <= S_SKID;
                            req_q      <= 1'b0;
                        end
                    end else if (br_d) begin
                        if_vld_q  <= 1'b0;
                        if_inst_q <= NOP_INST;
                        flush_q   <= 1'b1;
                        pc_q      <= branch_target;
                        // An outstanding request must complete at its own
                        // address before the target can be fetched.
                        if (!rsp_d) begin
                            req_addr_q  <= pc_q;
                            halt_pend_q <= 1'b0;
                            state_q     <= S_DRAIN;
                        end
                    end else if (hlt_d) begin
                        if_vld_q  <= 1'b0;
                        if_inst_q <= NOP_INST;
                        if (rsp_d) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                            req_q    <= 1'b0;
                        end else begin
                            req_addr_q  <= pc_q;
                            halt_pend_q <= 1'b1;
                            state_q     <= S_DRAIN;
                        end
                    end else if (rsp_d) begin
                        if_vld_q  <= 1'b1;
                        if_inst_q <= imem_data;
                        if_pc2_q  <= pc_plus2_d;
                        pc_q      <= pc_plus2_d;
                    end else begin
                        // IF/ID consumed its slot and nothing arrived: bubble.
                        if_vld_q  <= 1'b0;
                        if_inst_q <= NOP_INST;
                    end
                end
                S_SKID: begin
                    if (!stall) begin
                        if (br_d) begin
                            pc_q      <= branch_target;
                            if_vld_q  <= 1'b0;
                            if_inst_q <= NOP_INST;
                            flush_q   <= 1'b1;
                            state_q   <= S_FETCH;
                            req_q     <= 1'b1;
                        end else if (hlt_d) begin
                            if_vld_q  <= 1'b0;
                            if_inst_q <= NOP_INST;
                            state_q   <= S_HALT;
                            halted_q  <= 1'b1;
                        end else begin
                            if_vld_q  <= 1'b1;
                            if_inst_q <= skid_q;
                            if_pc2_q  <= skid_pc2_q;
                            state_q   <= S_FETCH;
                            req_q     <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if_vld_q  <= 1'b0;
                    if_inst_q <= NOP_INST;
                    // A further redirect only retargets; the drain continues.
                    if (br_d) begin
                        pc_q    <= branch_target;
                        flush_q <= 1'b1;
                    end
                    if (rsp_d) begin
                        if (halt_pend_q) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                            req_q    <= 1'b0;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: begin
                    req_q    <= 1'b0;
                    if_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = (state_q == S_DRAIN) ? req_addr_q : pc_q;
    assign if_vld      = if_vld_q;
    assign if_inst     = if_inst_q;
    assign if_pc_plus2 = if_pc2_q;
    assign flush       = flush_q;
    assign halted      = halted_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a transaction-level model of the
// fetch sequencer and a variable-latency memory predict every output cycle.
module tb_fetch_sequencer;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOP    = 16'h7F00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        hlt_dec;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_vld;
    logic [15:0] imem_data;
    logic        if_vld;
    logic [15:0] if_inst;
    logic [15:0] if_pc_plus2;
    logic        flush;
    logic        halted;
    logic [15:0] pc;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .hlt_dec(hlt_dec), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_vld(imem_vld), .imem_data(imem_data), .if_vld(if_vld),
        .if_inst(if_inst), .if_pc_plus2(if_pc_plus2), .flush(flush),
        .halted(halted), .pc(pc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0] ^ 8'hC3, a[15:8] ^ 8'h1E};
    endfunction

    // Reference model: what the fetch unit is doing, in transaction terms.
    bit          m_started, m_halted, m_draining, m_halt_after;
    logic [15:0] m_pc, m_drain_addr;
    logic [31:0] m_skid[$];
    logic        e_vld, e_flush;
    logic [15:0] e_inst, e_pc2;

    // Memory model: one outstanding request with a random latency.
    bit mem_out;
    int mem_lat;
    int max_lat, p_stall, p_br, p_hlt;

    function automatic bit pred_req();
        return m_started && !m_halted && (m_skid.size() == 0);
    endfunction

    function automatic logic [15:0] pred_addr();
        return m_draining ? m_drain_addr : m_pc;
    endfunction

    task automatic model_reset();
        m_started = 0; m_halted = 0; m_draining = 0; m_halt_after = 0;
        m_pc = RST_PC; m_skid.delete();
        e_vld = 0; e_inst = NOP; e_pc2 = 16'h0000; e_flush = 0;
    endtask

    task automatic kill_slot();
        e_vld  = 0;
        e_inst = NOP;
    endtask

    task automatic model_step(input bit s, input bit br_in, input bit hl_in,
                              input bit vld_in, input logic [15:0] tgt,
                              input logic [15:0] data);
        bit rsp, br, hl;
        logic [31:0] ent;
        rsp = vld_in && pred_req();
        br  = br_in && !s && !m_halted;
        hl  = hl_in && !s && !m_halted && !m_draining;
        e_flush = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (m_halted) begin
            // frozen until reset
        end else if (m_draining) begin
            kill_slot();
            if (br) begin m_pc = tgt; e_flush = 1; end
            if (rsp) begin
                m_draining = 0;
                if (m_halt_after) m_halted = 1;
            end
        end else if (m_skid.size() != 0) begin
            if (!s) begin
                ent = m_skid.pop_front();
                if (br) begin m_pc = tgt; kill_slot(); e_flush = 1; end
                else if (hl) begin kill_slot(); m_halted = 1; end
                else begin e_vld = 1; e_inst = ent[31:16]; e_pc2 = ent[15:0]; end
            end
        end else begin
            if (s) begin
                if (rsp) begin
                    m_skid.push_back({data, m_pc + 16'd2});
                    m_pc = m_pc + 16'd2;
                end
            end else if (br) begin
                kill_slot(); e_flush = 1;
                if (!rsp) begin m_draining = 1; m_drain_addr = m_pc; m_halt_after = 0; end
                m_pc = tgt;
            end else if (hl) begin
                kill_slot();
                if (rsp) m_halted = 1;
                else begin m_draining = 1; m_drain_addr = m_pc; m_halt_after = 1; end
            end else if (rsp) begin
                e_vld = 1; e_inst = data; e_pc2 = m_pc + 16'd2;
                m_pc = m_pc + 16'd2;
            end else begin
                kill_slot();
            end
        end
    endtask

    task automatic check_all();
        check_val("imem_req", {31'd0, imem_req}, {31'd0, pred_req()});
        if (pred_req()) check_val("imem_addr", {16'd0, imem_addr}, {16'd0, pred_addr()});
        check_val("if_vld", {31'd0, if_vld}, {31'd0, e_vld});
        check_val("if_inst", {16'd0, if_inst}, {16'd0, e_inst});
        check_val("if_pc_plus2", {16'd0, if_pc_plus2}, {16'd0, e_pc2});
        check_val("flush", {31'd0, flush}, {31'd0, e_flush});
        check_val("halted", {31'd0, halted}, {31'd0, m_halted});
        check_val("pc", {16'd0, pc}, {16'd0, m_pc});
    endtask

    task automatic do_reset(input int n);
        rst_n = 0; stall = 0; branch_taken = 0; hlt_dec = 0;
        branch_target = 16'h0000; imem_vld = 0; imem_data = 16'h0000;
        mem_out = 0; mem_lat = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            model_reset();
            #1 check_all();
        end
        rst_n = 1;
    endtask

    task automatic run_cycle();
        bit          s, b, h, v;
        logic [15:0] tgt, d;
        if (pred_req() && !mem_out) begin
            mem_out = 1;
            mem_lat = $urandom_range(0, max_lat);
        end
        v = mem_out && (mem_lat == 0);
        d = v ? mem_word(pred_addr()) : 16'($urandom);
        s = ($urandom_range(0, 99) < p_stall);
        b = m_started && ($urandom_range(0, 99) < p_br);
        h = m_started && ($urandom_range(0, 99) < p_hlt);
        tgt = 16'($urandom);
        case ($urandom_range(0, 3))
            0: tgt[0] = 1'b0;
            1: tgt = 16'hFFFC;
            2: tgt = 16'hFFFE;
            default: ;
        endcase
        stall = s; branch_taken = b; hlt_dec = h; branch_target = tgt;
        imem_vld = v; imem_data = d;
        @(posedge clk);
        cyc++;
        model_step(s, b, h, v, tgt, d);
        if (mem_out) begin
            if (v) mem_out = 0;
            else   mem_lat--;
        end
        #1 check_all();
    endtask

    initial begin
        for (int seg = 0; seg < 14; seg++) begin
            if (seg == 0) begin
                max_lat = 0; p_stall = 0; p_br = 0; p_hlt = 0;
            end else if (seg == 1) begin
                max_lat = 3; p_stall = 0; p_br = 0; p_hlt = 0;
            end else begin
                max_lat = seg % 4; p_stall = 25; p_br = 8;
                p_hlt = (seg % 3 == 0) ? 3 : 0;
            end
            do_reset(2);
            for (int c = 0; c < 200; c++) begin
                run_cycle();
                if (seg >= 2 && m_draining && c > 40 && $urandom_range(0, 3) == 0) break;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
